mcu_reg_bridge: RTL and testbench

//  SPI slave (mode 0) connecting the board MCU to the cart FPGA register file. Oversamples SCK/CS_N/MOSI in clk.

---
 rtl/mcu_reg_bridge.sv | 246 ++++++++++++++++++++++++
 tb/tb_mcu_reg_bridge.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_reg_bridge.sv
// mcu_reg_bridge: SPI mode-0 slave bridging the board MCU to the cart register file.
// Write frames commit wr_reg/wr_reg_addr and toggle wr_reg_changed; read frames
// return a 32-bit status_reg snapshot. Optional feature macro: SPI_WR_CRC_EN
// (write frames carry a CRC-8 byte; crc_err pulses on mismatch).
// Ports: clk, reset_n (async, active low); spi_sck/spi_cs_n/spi_mosi (async in);
//   spi_miso/spi_miso_oe (out); wr_reg, wr_reg_addr, wr_reg_changed (out);
//   status_reg (in); crc_err (out, 1-clk pulse).
module mcu_reg_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_BITS   = 4,
  parameter int DATA_BITS   = 16,
  parameter int STAT_BITS   = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 spi_sck,
  input  logic                 spi_cs_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  output logic [DATA_BITS-1:0] wr_reg,
  output logic [ADDR_BITS-1:0] wr_reg_addr,
  output logic                 wr_reg_changed,
  input  logic [STAT_BITS-1:0] status_reg,
  output logic                 crc_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WR_DATA, S_WR_CRC, S_RD_DATA, S_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] r_sck_s;
  logic [SYNC_STAGES-1:0] r_cs_s;
  logic [SYNC_STAGES-1:0] r_mosi_s;
  logic                   r_sck_d;
  logic                   r_cs_d;

  state_t                 r_state;
  logic [7:0]             r_cnt;
  logic [6:0]             r_cmd;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [DATA_BITS-1:0]   r_stage;
  logic [STAT_BITS-2:0]   r_shadow;
  logic                   r_commit;
  logic                   r_miso;
  logic                   r_oe;
  logic [DATA_BITS-1:0]   r_wr_reg;
  logic [ADDR_BITS-1:0]   r_wr_addr;
  logic                   r_wr_tog;

  logic                   w_sck;
  logic                   w_cs_n;
  logic                   w_mosi;
  logic                   w_sck_rise;
  logic                   w_sck_fall;
  logic                   w_cs_rise;
  logic                   w_cs_fall;
  logic [7:0]             w_cmd_byte;

  assign w_sck      = r_sck_s[SYNC_STAGES-1];
  assign w_cs_n     = r_cs_s[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_s[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  assign w_cs_rise  = w_cs_n & ~r_cs_d;
  assign w_cs_fall  = ~w_cs_n & r_cs_d;
  // Command byte as it will look once the current bit is shifted in.
  assign w_cmd_byte = {r_cmd, w_mosi};

  assign spi_miso       = r_miso;
  assign spi_miso_oe    = r_oe;
  assign wr_reg         = r_wr_reg;
  assign wr_reg_addr    = r_wr_addr;
  assign wr_reg_changed = r_wr_tog;

`ifdef SPI_WR_CRC_EN
  logic [7:0] r_crc_calc;
  logic [7:0] r_crc_rx;
  logic       r_crc_err;

  // Serial CRC-8, poly 0x07, MSB first.
  function automatic logic [7:0] f_crc8(input logic [7:0] c,
                                        input logic b);
    f_crc8 = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  assign crc_err = r_crc_err;
`else
  assign crc_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sck_s  <= '0;
      r_cs_s   <= '1;
      r_mosi_s <= '0;
      r_sck_d  <= 1'b0;
      r_cs_d   <= 1'b1;
    end else begin
      r_sck_s  <= {r_sck_s[SYNC_STAGES-2:0], spi_sck};
      r_cs_s   <= {r_cs_s[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], spi_mosi};
      r_sck_d  <= w_sck;
      r_cs_d   <= w_cs_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cmd     <= '0;
      r_addr    <= '0;
      r_stage   <= '0;
      r_shadow  <= '0;
      r_commit  <= 1'b0;
      r_miso    <= 1'b0;
      r_oe      <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_addr <= '0;
      r_wr_tog  <= 1'b0;
`ifdef SPI_WR_CRC_EN
      r_crc_calc <= '0;
      r_crc_rx   <= '0;
      r_crc_err  <= 1'b0;
`endif
    end else begin
      r_commit <= 1'b0;
      r_oe     <= ~w_cs_n;
`ifdef SPI_WR_CRC_EN
      r_crc_err <= 1'b0;
      if (r_commit) begin
        if (r_crc_calc == r_crc_rx) begin
          r_wr_reg  <= r_stage;
          r_wr_addr <= r_addr;
          r_wr_tog  <= ~r_wr_tog;
        end else begin
          r_crc_err <= 1'b1;
        end
      end
`else
      if (r_commit) begin
        r_wr_reg  <= r_stage;
        r_wr_addr <= r_addr;
        r_wr_tog  <= ~r_wr_tog;
      end
`endif
      // CS rise ends any frame and beats a same-cycle SCK edge.
      if (w_cs_rise) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_miso  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_miso <= 1'b0;
            if (w_cs_fall) begin
              r_state <= S_CMD;
              r_cnt   <= '0;
`ifdef SPI_WR_CRC_EN
              r_crc_calc <= '0;
`endif
            end
          end
          S_CMD: begin
            if (w_sck_rise) begin
              r_cmd <= w_cmd_byte[6:0];
`ifdef SPI_WR_CRC_EN
              r_crc_calc <= f_crc8(r_crc_calc, w_mosi);
`endif
              if (r_cnt == 8'd7) begin
                r_cnt  <= '0;
                r_addr <= w_cmd_byte[ADDR_BITS-1:0];
                if (w_cmd_byte[7]) begin
                  // Snapshot and present the MSB before the first data rise.
                  r_state  <= S_RD_DATA;
                  r_shadow <= status_reg[STAT_BITS-2:0];
                  r_miso   <= status_reg[STAT_BITS-1];
                end else begin
                  r_state <= S_WR_DATA;
                end
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
          end
          S_WR_DATA: begin
            if (w_sck_rise) begin
              r_stage <= {r_stage[DATA_BITS-2:0], w_mosi};
`ifdef SPI_WR_CRC_EN
              r_crc_calc <= f_crc8(r_crc_calc, w_mosi);
`endif
              if (r_cnt == 8'(DATA_BITS - 1)) begin
                r_cnt <= '0;
`ifdef SPI_WR_CRC_EN
                r_state <= S_WR_CRC;
`else
                r_state  <= S_DONE;
                r_commit <= 1'b1;
`endif
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
          end
`ifdef SPI_WR_CRC_EN
          S_WR_CRC: begin
            if (w_sck_rise) begin
              r_crc_rx <= {r_crc_rx[6:0], w_mosi};
              if (r_cnt == 8'd7) begin
                r_cnt    <= '0;
                r_state  <= S_DONE;
                r_commit <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
          end
`endif
          S_RD_DATA: begin
            // r_cnt counts data rises; the fall that ends the command
            // byte (r_cnt==0) must not shift.
            if (w_sck_rise) begin
              r_cnt <= r_cnt + 8'd1;
            end else if (w_sck_fall && r_cnt != 8'd0) begin
              if (r_cnt == 8'(STAT_BITS)) begin
                r_state <= S_DONE;
                r_miso  <= 1'b0;
              end else begin
                r_shadow <= {r_shadow[STAT_BITS-3:0], 1'b0};
                r_miso   <= r_shadow[STAT_BITS-2];
              end
            end
          end
          S_DONE: begin
            r_miso <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcu_reg_bridge.sv
// tb_mcu_reg_bridge: scoreboard bench for mcu_reg_bridge.
// Drives SPI mode-0 frames; commits and read bytes are checked against queues.
module tb_mcu_reg_bridge;

  logic        clk;
  logic        reset_n;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [15:0] wr_reg;
  logic [3:0]  wr_reg_addr;
  logic        wr_reg_changed;
  logic [31:0] status_reg;
  logic        crc_err;

  mcu_reg_bridge #(
    .SYNC_STAGES(2),
    .ADDR_BITS(4),
    .DATA_BITS(16),
    .STAT_BITS(32)
  ) u_dut (
    .clk(clk),
    .reset_n(reset_n),
    .spi_sck(spi_sck),
    .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .wr_reg(wr_reg),
    .wr_reg_addr(wr_reg_addr),
    .wr_reg_changed(wr_reg_changed),
    .status_reg(status_reg),
    .crc_err(crc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] rq[$];
  int         n_chk;
  int         n_err;
  int         n_tog;
  int         n_exp_tog;
  int         n_crc_err;
  time        t_rise;

  // Commit lands 2 sync flops + 1 sample clk + 1 commit clk after the
  // SCK rise is driven (inputs change on the falling clk edge).
  localparam time COMMIT_LAT = 35;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8_byte(input logic [7:0] c,
                                           input logic [7:0] b);
    logic [7:0] x;
    x = c ^ b;
    for (int i = 0; i < 8; i++)
      x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  // Commit monitor: every toggle pops one expected write.
  initial begin
    logic prev;
    time  t;
    wr_t  e;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      t = $time;
      #1;
      if (!reset_n) begin
        prev = 1'b0;
      end else if (wr_reg_changed !== prev) begin
        prev = wr_reg_changed;
        n_tog++;
        chk("commit_lat", 64'(t - t_rise), 64'(COMMIT_LAT));
        if (wq.size() == 0) begin
          chk("unexp_toggle", 64'd1, 64'd0);
        end else begin
          e = wq.pop_front();
          chk("wr_addr", 64'(wr_reg_addr), 64'(e.a));
          chk("wr_data", 64'(wr_reg), 64'(e.d));
        end
      end
      if (crc_err === 1'b1) n_crc_err++;
    end
  end

  task automatic spi_bit(input logic b, output logic r);
    @(negedge clk);
    spi_mosi = b;
    repeat (7) @(negedge clk);
    spi_sck = 1'b1;
    t_rise  = $time;
    r       = spi_miso;
    repeat (8) @(negedge clk);
    spi_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (8) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  task automatic wr_frame(input logic [7:0]  cmd,
                          input logic [15:0] d,
                          input logic        good);
    logic [7:0] rx;
    logic [7:0] c;
    wr_t        e;
    c = crc8_byte(8'h00, cmd);
    c = crc8_byte(c, d[15:8]);
    c = crc8_byte(c, d[7:0]);
    e.a = cmd[3:0];
    e.d = d;
`ifdef SPI_WR_CRC_EN
    if (good) begin
      wq.push_back(e);
      n_exp_tog++;
    end
`else
    wq.push_back(e);
    n_exp_tog++;
`endif
    cs_low();
    spi_byte(cmd, rx);
    spi_byte(d[15:8], rx);
    spi_byte(d[7:0], rx);
`ifdef SPI_WR_CRC_EN
    spi_byte(good ? c : (c ^ 8'h03), rx);
`else
    if (!good) spi_byte(c, rx);
`endif
    cs_high();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rx;
    logic       b;
    int         tog0;
    int         crc0;
    n_chk     = 0;
    n_err     = 0;
    n_tog     = 0;
    n_exp_tog = 0;
    n_crc_err = 0;
    t_rise    = 0;
    reset_n    = 1'b0;
    spi_sck    = 1'b0;
    spi_cs_n   = 1'b1;
    spi_mosi   = 1'b0;
    status_reg = '0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_wr_reg", 64'(wr_reg), 64'd0);
    chk("rst_addr", 64'(wr_reg_addr), 64'd0);
    chk("rst_tog", 64'(wr_reg_changed), 64'd0);
    chk("rst_miso", 64'(spi_miso), 64'd0);
    chk("rst_oe", 64'(spi_miso_oe), 64'd0);
    chk("rst_crc_err", 64'(crc_err), 64'd0);

    // Basic write.
    wr_frame(8'h03, 16'h1234, 1'b1);
    chk("w1_tog", 64'(wr_reg_changed), 64'd1);

    // Aborted write: CS rises 4 bits into the second data byte.
    tog0 = n_tog;
    cs_low();
    spi_byte(8'h01, rx);
    spi_byte(8'hAB, rx);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
    cs_high();
    chk("abort_tog", 64'(n_tog), 64'(tog0));
    chk("abort_data", 64'(wr_reg), 64'h1234);
    chk("abort_addr", 64'(wr_reg_addr), 64'd3);

    // Back-to-back writes; a frame with extra bits past the data is ignored.
    tog0 = n_tog;
    wr_frame(8'h00, 16'h0001, 1'b1);
    wr_frame(8'h71, 16'h0008, 1'b0);
    chk("b2b_tog", 64'(n_tog - tog0), 64'd2);
    chk("b2b_addr", 64'(wr_reg_addr), 64'd1);
    chk("b2b_data", 64'(wr_reg), 64'h0008);

    // Read with status changing mid-frame.
    status_reg = 32'hA5C3_0F01;
    rq.push_back(8'hA5);
    rq.push_back(8'hC3);
    rq.push_back(8'h0F);
    rq.push_back(8'h01);
    cs_low();
    spi_byte(8'h80, rx);
    status_reg = 32'h0;
    chk("rd_oe_on", 64'(spi_miso_oe), 64'd1);
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, rx);
      if (rq.size() == 0) chk("rd_q_empty", 64'd1, 64'd0);
      else chk("rd_byte", 64'(rx), 64'(rq.pop_front()));
    end
    repeat (8) @(negedge clk);
    chk("rd_miso_done", 64'(spi_miso), 64'd0);
    cs_high();
    chk("rd_oe_off", 64'(spi_miso_oe), 64'd0);
    chk("rd_miso_idle", 64'(spi_miso), 64'd0);

    // Async reset mid-write.
    cs_low();
    spi_byte(8'h02, rx);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_data", 64'(wr_reg), 64'd0);
    chk("mid_rst_addr", 64'(wr_reg_addr), 64'd0);
    chk("mid_rst_tog", 64'(wr_reg_changed), 64'd0);
    chk("mid_rst_oe", 64'(spi_miso_oe), 64'd0);
    chk("mid_rst_miso", 64'(spi_miso), 64'd0);
    spi_cs_n = 1'b1;
    spi_sck  = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    wr_frame(8'h05, 16'hBEEF, 1'b1);
    chk("post_rst_tog", 64'(wr_reg_changed), 64'd1);

`ifdef SPI_WR_CRC_EN
    crc0 = n_crc_err;
    tog0 = n_tog;
    wr_frame(8'h00, 16'h0001, 1'b1);
    wr_frame(8'h00, 16'h0001, 1'b0);
    chk("crc_tog", 64'(n_tog - tog0), 64'd1);
    chk("crc_err_cnt", 64'(n_crc_err - crc0), 64'd1);
`else
    crc0 = 0;
    chk("crc_err_tied", 64'(n_crc_err), 64'(crc0));
`endif

    repeat (50) @(negedge clk);
    chk("sb_wr_left", 64'(wq.size()), 64'd0);
    chk("sb_rd_left", 64'(rq.size()), 64'd0);
    chk("toggles", 64'(n_tog), 64'(n_exp_tog));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
